// File: rtl/j1_wb_defs_pkg.sv
// Shared Wishbone definitions for the J1 system bus: arbiter state encodings,
// default bus widths and master index constants.
package j1_wb_defs;

    localparam int unsigned DEF_AW = 16;
    localparam int unsigned DEF_DW = 16;

    localparam int unsigned CPU    = 0;
    localparam int unsigned LOADER = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // One-hot owner vector for a given arbiter state.
    function automatic logic [1:0] gnt_of(input arb_state_t st);
        logic [1:0] g;
        g = 2'b00;
        case (st)
            OWN0:    g = 2'b01;
            OWN1:    g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts consecutive unterminated strobe cycles and flags
// expiry on the TIMEOUT-th one, then starts a fresh count.
module wb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Count holds the number of stalled cycles already elapsed, so the current
    // stalled cycle is the TIMEOUT-th when cnt == TIMEOUT-1.
    assign expire = inc && !clr && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || expire) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/wb_arb2.sv
// Two-master Wishbone classic arbiter: round-robin grant held for a full cyc
// tenure, combinational datapath muxing, watchdog-generated err on stalls.
module wb_arb2
    import j1_wb_defs::*;
#(
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_in,
    input  logic              rst_n,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DW-1:0]     m0_dat_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DW-1:0]     m1_dat_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic [DW-1:0]     s_dat_i,

    output logic [1:0]        gnt_o
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;

    logic own_cyc;
    logic own_stb;
    logic wd_clr;
    logic wd_inc;
    logic expire;

    // Owner request lines, kept separate from the output mux to keep the
    // watchdog path free of combinational feedback.
    assign own_cyc = (state_q == OWN0) ? m0_cyc_i :
                     (state_q == OWN1) ? m1_cyc_i : 1'b0;
    assign own_stb = (state_q == OWN0) ? m0_stb_i :
                     (state_q == OWN1) ? m1_stb_i : 1'b0;

    assign wd_clr = (state_q == IDLE) || s_ack_i || s_err_i;
    assign wd_inc = own_cyc && own_stb && !s_ack_i && !s_err_i;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .inc     (wd_inc),
        .expire  (expire)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'(LOADER);
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign gnt_o = gnt_of(state_q);

    // Next-state and datapath mux; everything idles at zero outside a tenure.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;

        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = (last_q == 1'(LOADER)) ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    state_d = OWN0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                end
            end

            OWN0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i && !expire;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i || expire;
                m0_dat_o = s_dat_i;
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'(CPU);
                end
            end

            OWN1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i && !expire;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i || expire;
                m1_dat_o = s_dat_i;
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'(LOADER);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/wb_arb2.md
# wb_arb2

Two-master Wishbone classic arbiter that shares the single system bus (program/data RAM and the UART/IO slaves) between the J1 CPU data port (master 0) and the UART boot/debug loader (master 1). It sits inside `j1_top` between the masters and the slave address decoder. It grants the bus round-robin and holds the grant for a whole `cyc` tenure. A watchdog terminates stalled cycles with `err`.

## Interface
Parameters:
- `AW`, 16, address width (word address).
- `DW`, 16, data width; `SW = DW/8` select lines.
- `TIMEOUT`, 255, stalled-cycle limit before `err` (legal range 2..65535).

Ports:
- `clk_in` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: CPU request.
- `m0_adr_i` in AW, `m0_dat_i` in DW, `m0_sel_i` in SW: CPU address, write data, byte selects.
- `m0_ack_o`, `m0_err_o` out 1: CPU termination.
- `m0_dat_o` out DW: CPU read data.
- `m1_*`: identical set for the loader.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1; `s_adr_o` out AW; `s_dat_o` out DW; `s_sel_o` out SW: to slave decoder.
- `s_ack_i` in 1, `s_err_i` in 1, `s_dat_i` in DW: from slave decoder.
- `gnt_o` out 2: one-hot current owner (debug/LED).

## Operation
- FSM states: IDLE, OWN0, OWN1 (registered). `last` flag records the most recent owner; reset value = 1, so master 0 wins the first contention.
- IDLE: if exactly one `mX_cyc_i` is high, go to OWNX. If both are high, go to the master ≠ `last`. If neither is high, stay.
- OWNX: slave outputs are muxed combinationally from master X. `s_ack_i`, `s_err_i` and `s_dat_i` route only to master X. Non-owner `ack/err` = 0, `dat_o` = 0.
- Release: when the owner drops `cyc`, go to IDLE next cycle and set `last` = X. There is always ≥1 IDLE cycle between tenures; no back-to-back handover.
- Watchdog: a counter clears on entry to OWNX and on each `s_ack_i` or `s_err_i`. It increments each cycle the owner's `stb` is high with no termination.
  - When it reaches TIMEOUT, `mX_err_o` = 1 for exactly one cycle.
  - `s_stb_o` is masked to 0 that cycle, and the counter clears.
  - The owner keeps the grant until it drops `cyc`.
- `s_ack_i` and `s_err_i` together: both are passed through; the master treats it as error.
- Requests from the non-owner are ignored (no queueing beyond the level-held `cyc`).
- `rst_n` low mid-tenure: next edge returns to IDLE, `last` = 1, counter = 0. All outputs go low from that edge.

## Timing
- Reset values: `s_cyc_o`, `s_stb_o`, `s_we_o` = 0; `s_adr_o`, `s_dat_o`, `s_sel_o` = 0; all `m*_ack_o`/`m*_err_o` = 0; `m*_dat_o` = 0; `gnt_o` = 2'b00.
- Grant latency: `cyc` rising at edge N (sampled in IDLE) puts the FSM in OWNX after edge N+1. `s_cyc_o` is high in cycle N+1. Arbitration adds 1 cycle.
- Inside a tenure, paths are combinational: `ack` latency equals the slave's latency; there is no added pipeline.
- Timeout `err` asserts in the cycle in which the count equals TIMEOUT, i.e. after TIMEOUT stalled cycles.
- `gnt_o` mirrors the FSM state register.
- In IDLE, all slave outputs are 0; address and data are not passed through.

## Structure
- Shared header/package `j1_wb_defs`: state encodings (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2), default AW/DW, and the master index constants (CPU=0, LOADER=1).
- One sub-module, `wb_watchdog`: parameter TIMEOUT; inputs `clk_in`, `rst_n`, `clr`, `inc`; output `expire`.
- The arbiter FSM and the muxes live in `wb_arb2`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with both `cyc` high. All outputs must be 0 and `gnt_o`=00. Release reset: `gnt_o`=01 one cycle later.
- Single master: m1 writes 0xBEEF to 0x0010 with a slave ack after 2 cycles. Required: `s_adr_o`=0x0010, `s_dat_o`=0xBEEF, `m1_ack_o` one cycle, `m0_ack_o` stays 0.
- Contention: both raise `cyc` in the same cycle (after reset). Required grant order: m0 first. m0 drops `cyc` → 1 IDLE cycle → m1 granted. Repeating alternates 01, 10, 01.
- Read routing: m0 reads while the slave returns `s_dat_i`=0x1234. Required: `m0_dat_o`=0x1234 on the ack cycle, `m1_dat_o`=0.
- Timeout: TIMEOUT=4, m0 `stb` held, no ack. Required: `m0_err_o` high exactly on the 4th stalled cycle and `s_stb_o` low that cycle, then a new count.
- Reset mid-tenure: `rst_n` pulsed low during OWN1. Required: next edge IDLE, outputs 0. With both requesting after release, m0 is granted.
